sw_debounce8: RTL and testbench



---
 rtl/debounce_pkg.sv | 13 +
 rtl/debounce_bit.sv | 57 +++++
 rtl/sw_debounce8.sv | 46 ++++
 tb/tb_sw_debounce8.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared debounce constants, also reused by the encoder stage for its own switch inputs.
package debounce_pkg;

    localparam int DEFAULT_STABLE_CYCLES = 50000;
    localparam int SIM_STABLE_CYCLES     = 4;
    localparam int DEFAULT_CNT_W         = 16;

    // True when a CNT_W-bit counter can reach cycles-1 without wrapping.
    function automatic bit cnt_fits(input int cycles, input int cnt_w);
        return (cycles >= 1) && (longint'(cycles) <= ((longint'(1) << cnt_w) - 1));
    endfunction

endpackage

// File: rtl/debounce_bit.sv
// One switch channel: two-flop synchroniser, stability counter, debounced level and edge pulses.
module debounce_bit
    import debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic sw_in,
    output logic sw_out,
    output logic rise,
    output logic fall,
    output logic hit
);

    localparam bit              CFG_OK = cnt_fits(STABLE_CYCLES, CNT_W);
    localparam logic [CNT_W-1:0] TC    = CNT_W'(STABLE_CYCLES - 1);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // Acceptance on the coming edge; the top registers the OR of these as `changed`.
    assign hit = en && (s2 != sw_out) && (cnt == TC);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            sw_out <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            assert (CFG_OK) else $error("debounce_bit: CNT_W=%0d cannot hold STABLE_CYCLES=%0d", CNT_W, STABLE_CYCLES);
            s1   <= sw_in;
            s2   <= s1;
            rise <= 1'b0;
            fall <= 1'b0;
            if (en) begin
                if (s2 == sw_out) begin
                    cnt <= '0;
                end else if (cnt == TC) begin
                    sw_out <= s2;
                    cnt    <= '0;
                    rise   <= s2;
                    fall   <= ~s2;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sw_debounce8.sv
// Eight-channel switch synchroniser/debouncer feeding the priority encoder stage.
module sw_debounce8
    import debounce_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] sw_in,
    output logic [WIDTH-1:0] sw_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    logic [WIDTH-1:0] hit;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_bit #(
            .STABLE_CYCLES(STABLE_CYCLES),
            .CNT_W        (CNT_W)
        ) u_bit (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en),
            .sw_in (sw_in[i]),
            .sw_out(sw_out[i]),
            .rise  (rise[i]),
            .fall  (fall[i]),
            .hit   (hit[i])
        );
    end

    // Registered from the same acceptance terms so it lines up with rise/fall.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            changed <= 1'b0;
        end else begin
            changed <= |hit;
        end
    end

endmodule

// File: tb/tb_sw_debounce8.sv
// Table-driven bench for sw_debounce8 with STABLE_CYCLES=4, CNT_W=4.
module tb_sw_debounce8;
    import debounce_pkg::*;

    localparam int W  = 8;
    localparam int S  = SIM_STABLE_CYCLES;
    localparam int CW = 4;

    typedef struct {
        string      tag;
        logic       rst_n;
        logic       en;
        logic [7:0] sw;
        logic [7:0] out;
        logic [7:0] ri;
        logic [7:0] fa;
        logic       ch;
    } vec_t;

    typedef struct {
        string       tag;
        logic [24:0] val;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [W-1:0] sw_in;
    logic [W-1:0] sw_out;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic         changed;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    sw_debounce8 #(
        .WIDTH        (W),
        .STABLE_CYCLES(S),
        .CNT_W        (CW)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (en),
        .sw_in  (sw_in),
        .sw_out (sw_out),
        .rise   (rise),
        .fall   (fall),
        .changed(changed)
    );

    task automatic add_rows(input string tag, input int n, input logic r, input logic e,
                            input logic [7:0] sw, input logic [7:0] out,
                            input logic [7:0] ri, input logic [7:0] fa, input logic ch);
        for (int i = 0; i < n; i++) begin
            vec_t v;
            v.tag = tag; v.rst_n = r; v.en = e; v.sw = sw;
            v.out = out; v.ri = ri; v.fa = fa; v.ch = ch;
            vecs.push_back(v);
        end
    endtask

    task automatic check(input string tag, input logic [24:0] got, input logic [24:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got out=%h rise=%h fall=%h ch=%b, want out=%h rise=%h fall=%h ch=%b",
                     tag, got[24:17], got[16:9], got[8:1], got[0],
                     want[24:17], want[16:9], want[8:1], want[0]);
        end
    endtask

    // Drive one cycle at the falling edge, queue the expectation, compare just after the rising edge.
    task automatic drive_and_check(input string tag, input logic r, input logic e,
                                   input logic [7:0] sw, input logic [24:0] want);
        exp_t x;
        @(negedge clk);
        rst_n = r; en = e; sw_in = sw;
        x.tag = tag; x.val = want;
        exp_q.push_back(x);
        @(posedge clk);
        #1;
        x = exp_q.pop_front();
        check(x.tag, {sw_out, rise, fall, changed}, x.val);
    endtask

    initial begin
        int hit_cycle;

        rst_n = 1'b0; en = 1'b0; sw_in = '0;

        // Reset with pins high, en low: reset wins; accept on 6th edge after release.
        add_rows("rst_hold",   3, 0, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
        add_rows("rst_wait",   5, 1, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 0);
        add_rows("rst_accept", 1, 1, 1, 8'hFF, 8'hFF, 8'hFF, 8'h00, 1);
        add_rows("rst_after",  1, 1, 1, 8'hFF, 8'hFF, 8'h00, 8'h00, 0);
        // Falling edges on all bits.
        add_rows("fall_wait",   5, 1, 1, 8'h00, 8'hFF, 8'h00, 8'h00, 0);
        add_rows("fall_accept", 1, 1, 1, 8'h00, 8'h00, 8'h00, 8'hFF, 1);
        add_rows("fall_after",  1, 1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        // Bounce on bit 0: 1,1,0,0,1,1,0,0 then held 1.
        for (int b = 0; b < 8; b++) begin
            logic [7:0] sw_b;
            sw_b = ((b / 2) % 2 == 0) ? 8'h01 : 8'h00;
            add_rows("bounce", 1, 1, 1, sw_b, 8'h00, 8'h00, 8'h00, 0);
        end
        add_rows("bounce_wait",   5, 1, 1, 8'h01, 8'h00, 8'h00, 8'h00, 0);
        add_rows("bounce_accept", 1, 1, 1, 8'h01, 8'h01, 8'h01, 8'h00, 1);
        add_rows("bounce_after",  1, 1, 1, 8'h01, 8'h01, 8'h00, 8'h00, 0);
        add_rows("b0_fall_wait",   5, 1, 1, 8'h00, 8'h01, 8'h00, 8'h00, 0);
        add_rows("b0_fall_accept", 1, 1, 1, 8'h00, 8'h00, 8'h00, 8'h01, 1);
        add_rows("b0_fall_after",  1, 1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        // Enable gap on bit 3: two counted edges, five held, accept on edge 11.
        add_rows("en_count",  4, 1, 1, 8'h08, 8'h00, 8'h00, 8'h00, 0);
        add_rows("en_gap",    5, 1, 0, 8'h08, 8'h00, 8'h00, 8'h00, 0);
        add_rows("en_resume", 1, 1, 1, 8'h08, 8'h00, 8'h00, 8'h00, 0);
        add_rows("en_accept", 1, 1, 1, 8'h08, 8'h08, 8'h08, 8'h00, 1);
        add_rows("en_after",  1, 1, 1, 8'h08, 8'h08, 8'h00, 8'h00, 0);
        add_rows("b3_fall_wait",   5, 1, 1, 8'h00, 8'h08, 8'h00, 8'h00, 0);
        add_rows("b3_fall_accept", 1, 1, 1, 8'h00, 8'h00, 8'h00, 8'h08, 1);
        add_rows("b3_fall_after",  1, 1, 1, 8'h00, 8'h00, 8'h00, 8'h00, 0);
        // Simultaneous rises on bits 7 and 0.
        add_rows("simul_wait",   5, 1, 1, 8'h81, 8'h00, 8'h00, 8'h00, 0);
        add_rows("simul_accept", 1, 1, 1, 8'h81, 8'h81, 8'h81, 8'h00, 1);
        add_rows("simul_after",  1, 1, 1, 8'h81, 8'h81, 8'h00, 8'h00, 0);
        // Reset at edge 3 of a pending rise on bit 5, then full re-acceptance.
        add_rows("midrst_count", 3, 1, 1, 8'hA1, 8'h81, 8'h00, 8'h00, 0);
        add_rows("midrst_rst",   1, 0, 1, 8'hA1, 8'h00, 8'h00, 8'h00, 0);
        add_rows("midrst_wait",  5, 1, 1, 8'hA1, 8'h00, 8'h00, 8'h00, 0);
        add_rows("midrst_accept",1, 1, 1, 8'hA1, 8'hA1, 8'hA1, 8'h00, 1);
        add_rows("midrst_after", 1, 1, 1, 8'hA1, 8'hA1, 8'h00, 8'h00, 0);

        foreach (vecs[i])
            drive_and_check(vecs[i].tag, vecs[i].rst_n, vecs[i].en, vecs[i].sw,
                            {vecs[i].out, vecs[i].ri, vecs[i].fa, vecs[i].ch});

        // Single-sample glitch on bit 1 must never reach the output.
        drive_and_check("glitch_hi", 1, 1, 8'hA3, {8'hA1, 8'h00, 8'h00, 1'b0});
        for (int i = 0; i < 8; i++)
            drive_and_check("glitch_hold", 1, 1, 8'hA1, {8'hA1, 8'h00, 8'h00, 1'b0});

        // Bounded wait for the falling acceptance of all set bits.
        @(negedge clk);
        sw_in = 8'h00;
        hit_cycle = -1;
        for (int c = 0; c < 20 && hit_cycle < 0; c++) begin
            @(posedge clk);
            #1;
            if (changed === 1'b1) begin
                hit_cycle = c;
                check("wait_fall_vals", {sw_out, rise, fall, changed}, {8'h00, 8'h00, 8'hA1, 1'b1});
            end
        end
        checks++;
        if (hit_cycle != S + 1) begin
            failures++;
            $display("FAIL wait_fall_latency: got edge %0d, want edge %0d", hit_cycle, S + 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
